// File: rtl/stream_mux_ctrl_pkg.sv
// Shared definitions for the stream mux switch controller: FSM state
// encoding, parameter defaults and internal counter widths.
package stream_mux_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_GATE  = 2'd2
  } state_e;

  localparam int DEF_SEL_WIDTH    = 1;
  localparam int DEF_GUARD_CYCLES = 4;
  localparam int DEF_TIMEOUT      = 1024;

  // The drain counter is wide enough for any practical TIMEOUT.
  // The guard counter covers GUARD_CYCLES up to 255.
  localparam int DRAIN_CNT_W = 32;
  localparam int GATE_CNT_W  = 8;

endpackage

// File: rtl/stream_mux_ctrl_axis_pkt_tracker.sv
// Tracks whether the monitored AXI-Stream is in the middle of a packet.
// A beat handshake with tlast=0 opens or continues a packet. A handshake
// with tlast=1 closes it. The clear input abandons the current packet.
module axis_pkt_tracker
  import stream_mux_ctrl_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic tvalid,
  input  logic tready,
  input  logic tlast,
  input  logic clear,
  output logic in_packet,
  output logic boundary
);

  logic hs;
  logic in_packet_q;
  logic in_packet_d;

  assign hs        = tvalid & tready;
  assign boundary  = hs & tlast;
  assign in_packet = in_packet_q;

  // Next packet state: clear wins, otherwise follow the handshake's tlast.
  always_comb begin
    in_packet_d = in_packet_q;
    if (clear) begin
      in_packet_d = 1'b0;
    end else if (hs) begin
      in_packet_d = ~tlast;
    end else begin
      in_packet_d = in_packet_q;
    end
  end

  // In-packet flag register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      in_packet_q <= 1'b0;
    end else begin
      in_packet_q <= in_packet_d;
    end
  end

endmodule

// File: rtl/stream_mux_ctrl.sv
// Stream mux switch controller. It accepts a select/enable request, lets
// the current packet drain, and gates the mux off for a guard period while
// it changes select. It then re-enables the mux and pulses done. A drain
// that stalls too long is forced closed with a frame-drop command.
module stream_mux_ctrl
  import stream_mux_ctrl_pkg::*;
#(
  parameter int SEL_WIDTH    = DEF_SEL_WIDTH,
  parameter int GUARD_CYCLES = DEF_GUARD_CYCLES,
  parameter int TIMEOUT      = DEF_TIMEOUT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [SEL_WIDTH-1:0] req_sel,
  input  logic                 req_enable,
  input  logic                 mon_tvalid,
  input  logic                 mon_tready,
  input  logic                 mon_tlast,
  output logic                 enable,
  output logic                 drop,
  output logic [SEL_WIDTH-1:0] sel,
  output logic                 done,
  output logic                 timeout_err
);

  state_e                 state_q, state_d;
  logic [SEL_WIDTH-1:0]   tgt_sel_q, tgt_sel_d;
  logic                   tgt_en_q, tgt_en_d;
  logic                   enable_q, enable_d;
  logic                   drop_q, drop_d;
  logic [SEL_WIDTH-1:0]   sel_q, sel_d;
  logic                   done_q, done_d;
  logic                   tmo_q, tmo_d;
  logic                   ready_q, ready_d;
  logic [DRAIN_CNT_W-1:0] drain_cnt_q, drain_cnt_d;
  logic [GATE_CNT_W-1:0]  gate_cnt_q, gate_cnt_d;

  logic mon_hs;
  logic in_packet;
  logic boundary;
  logic trk_clear;

  assign mon_hs = mon_tvalid & mon_tready;

  axis_pkt_tracker u_trk (
    .clk       (clk),
    .rst       (rst),
    .tvalid    (mon_tvalid),
    .tready    (mon_tready),
    .tlast     (mon_tlast),
    .clear     (trk_clear),
    .in_packet (in_packet),
    .boundary  (boundary)
  );

  // Next-state and next-output logic. Outputs hold unless a transition
  // changes them. done and timeout_err are single-cycle pulses.
  always_comb begin
    state_d     = state_q;
    tgt_sel_d   = tgt_sel_q;
    tgt_en_d    = tgt_en_q;
    enable_d    = enable_q;
    drop_d      = drop_q;
    sel_d       = sel_q;
    done_d      = 1'b0;
    tmo_d       = 1'b0;
    drain_cnt_d = drain_cnt_q;
    gate_cnt_d  = gate_cnt_q;
    trk_clear   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid && ready_q) begin
          if ((req_sel == sel_q) && (req_enable == enable_q)) begin
            // Already where the request wants to be: acknowledge only.
            done_d = 1'b1;
          end else begin
            tgt_sel_d   = req_sel;
            tgt_en_d    = req_enable;
            drain_cnt_d = '0;
            state_d     = ST_DRAIN;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_DRAIN: begin
        if (boundary || (!in_packet && !mon_hs)) begin
          // Packet finished, or the stream is between packets: gate now.
          state_d    = ST_GATE;
          enable_d   = 1'b0;
          sel_d      = tgt_sel_q;
          drop_d     = 1'b0;
          gate_cnt_d = '0;
        end else if ((TIMEOUT > 0) &&
                     (drain_cnt_q == DRAIN_CNT_W'(TIMEOUT - 1))) begin
          // Stalled packet: force the switch and have the mux flush it.
          state_d    = ST_GATE;
          enable_d   = 1'b0;
          sel_d      = tgt_sel_q;
          drop_d     = 1'b1;
          tmo_d      = 1'b1;
          trk_clear  = 1'b1;
          gate_cnt_d = '0;
        end else begin
          drain_cnt_d = drain_cnt_q + DRAIN_CNT_W'(1);
        end
      end
      ST_GATE: begin
        if (gate_cnt_q == GATE_CNT_W'(GUARD_CYCLES - 1)) begin
          state_d  = ST_IDLE;
          enable_d = tgt_en_q;
          drop_d   = 1'b0;
          done_d   = 1'b1;
        end else begin
          gate_cnt_d = gate_cnt_q + GATE_CNT_W'(1);
        end
      end
      default: begin
        state_d  = ST_IDLE;
        enable_d = 1'b0;
        drop_d   = 1'b0;
      end
    endcase
    ready_d = (state_d == ST_IDLE);
  end

  // State and registered-output update with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      tgt_sel_q   <= '0;
      tgt_en_q    <= 1'b0;
      enable_q    <= 1'b0;
      drop_q      <= 1'b0;
      sel_q       <= '0;
      done_q      <= 1'b0;
      tmo_q       <= 1'b0;
      ready_q     <= 1'b0;
      drain_cnt_q <= '0;
      gate_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      tgt_sel_q   <= tgt_sel_d;
      tgt_en_q    <= tgt_en_d;
      enable_q    <= enable_d;
      drop_q      <= drop_d;
      sel_q       <= sel_d;
      done_q      <= done_d;
      tmo_q       <= tmo_d;
      ready_q     <= ready_d;
      drain_cnt_q <= drain_cnt_d;
      gate_cnt_q  <= gate_cnt_d;
    end
  end

  assign req_ready   = ready_q;
  assign enable      = enable_q;
  assign drop        = drop_q;
  assign sel         = sel_q;
  assign done        = done_q;
  assign timeout_err = tmo_q;

endmodule

// File: doc/stream_mux_ctrl.md
STREAM_MUX_CTRL -- requirements
Module: stream_mux_ctrl

Interface
REQ-001 Parameter SEL_WIDTH, default 1: width of the mux select.
REQ-002 Parameter GUARD_CYCLES, default 4, legal range 1..255: cycles enable is held low during a switch.
REQ-003 Parameter TIMEOUT, default 1024, 0 disables: maximum drain cycles before a forced flush.
REQ-004 clk  in  1  sole clock; all logic rising-edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 req_valid  in  1  switch request strobe.
REQ-007 req_ready  out  1  controller can accept a request.
REQ-008 req_sel  in  SEL_WIDTH  target mux input.
REQ-009 req_enable  in  1  target enable after the switch (0 = park the mux disabled).
REQ-010 mon_tvalid, mon_tready, mon_tlast  in  1 each  taps of the mux output AXI-Stream.
REQ-011 enable  out  1  mux enable.
REQ-012 drop  out  1  mux frame-drop (flush) command.
REQ-013 sel  out  SEL_WIDTH  mux select.
REQ-014 done  out  1  one-cycle pulse when a request completes.
REQ-015 timeout_err  out  1  one-cycle pulse when a drain times out.

Function
REQ-016 A request SHALL be accepted on a cycle with req_valid=1 and req_ready=1; req_ready SHALL be 1 only in IDLE.
REQ-017 The block SHALL track in_packet: set on a mon handshake with tlast=0, cleared on a handshake with tlast=1, cleared by timeout or reset.
REQ-018 States: IDLE, DRAIN, GATE. On acceptance, req_sel/req_enable SHALL be latched and the state SHALL become DRAIN, except as in REQ-019.
REQ-019 If req_sel equals sel and req_enable equals enable, the block SHALL stay in IDLE, leave outputs unchanged, and pulse done on the following cycle.
REQ-020 In DRAIN, enable/sel/drop SHALL hold. DRAIN SHALL exit to GATE on a cycle with a handshake with tlast=1, or with in_packet=0 and no handshake.
REQ-021 In DRAIN, a handshake with tlast=0 while in_packet=0 (packet start) SHALL keep the block in DRAIN.
REQ-022 A drain counter SHALL count DRAIN cycles from 0. If TIMEOUT>0 and the count reaches TIMEOUT-1 without exit, the block SHALL enter GATE with drop=1, clear in_packet, and pulse timeout_err in that transition cycle.
REQ-023 On entry to GATE, enable SHALL go 0 and sel SHALL take the latched target in the same cycle. The block SHALL remain in GATE for exactly GUARD_CYCLES cycles.
REQ-024 drop SHALL be 1 only during GATE cycles entered via timeout.
REQ-025 On leaving GATE, the block SHALL go to IDLE with enable=latched req_enable and drop=0, and pulse done in that first IDLE cycle.
REQ-026 Latency with an idle stream: acceptance at cycle N SHALL give enable=0 on cycles N+2..N+GUARD_CYCLES+1, and done on cycle N+GUARD_CYCLES+2.
REQ-027 A disabled mux (enable=0) SHALL still run DRAIN/GATE; with no traffic, DRAIN exits after one cycle.
REQ-028 req_valid while not in IDLE SHALL be ignored, with no queuing.

Reset
REQ-029 While rst=1: state=IDLE, enable=0, drop=0, sel=0, done=0, timeout_err=0, in_packet=0, counters=0, req_ready=0.
REQ-030 After rst deasserts, req_ready SHALL be 1 from the first cycle. Reset mid-DRAIN or mid-GATE SHALL abort with no done pulse.

Structure
REQ-031 State encoding (IDLE=0, DRAIN=1, GATE=2) and the parameter defaults SHALL live in the shared package/header stream_mux_ctrl_pkg.
REQ-032 Packet-boundary tracking (REQ-017) SHALL be a sub-module axis_pkt_tracker (inputs clk, rst, tvalid, tready, tlast, clear; outputs in_packet, boundary).
REQ-033 All outputs SHALL be registered.

Verification
REQ-034 Idle stream, GUARD_CYCLES=4, request sel=1/enable=1 at cycle 10 -> enable=0 on cycles 12-15, sel=1 from 12, enable=1 and done on cycle 16.
REQ-035 Packet of 8 beats in flight (3 sent), request sel=0 -> enable held 1 until the tlast beat, enable=0 the next cycle, done GUARD_CYCLES+1 cycles after that, no beat lost.
REQ-036 TIMEOUT=16, packet stalled (tready=0) mid-frame, request -> timeout_err on drain count 15, drop=1 for 4 GATE cycles, in_packet cleared.
REQ-037 Request equal to current sel/enable -> done on the next cycle, enable never drops. req_valid during GATE -> ignored, req_ready=0.
REQ-038 rst asserted on the second GATE cycle -> all outputs 0 the next cycle, no done, req_ready=1 the cycle after rst deasserts.
